// File: rtl/axi_wr_to_mem_if.sv
// AXI4 write-channel bundle (AW, W, B) between the HLS kernel master and the bridge.
// Signal names keep the AXI upper-case spelling so hierarchical names read m_axi_data.AWVALID.
interface axi_wr_to_mem_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 1,
    parameter int USER_BITS = 1
);
    // write address channel
    logic                   AWVALID;
    logic                   AWREADY;
    logic [ADDR_BITS-1:0]   AWADDR;
    logic [ID_BITS-1:0]     AWID;
    logic [7:0]             AWLEN;
    logic [2:0]             AWSIZE;
    logic [1:0]             AWBURST;
    logic                   AWLOCK;
    logic [3:0]             AWCACHE;
    logic [2:0]             AWPROT;
    logic [3:0]             AWQOS;
    logic [3:0]             AWREGION;
    logic [USER_BITS-1:0]   AWUSER;

    // write data channel
    logic                   WVALID;
    logic                   WREADY;
    logic [DATA_BITS-1:0]   WDATA;
    logic [DATA_BITS/8-1:0] WSTRB;
    logic                   WLAST;
    logic [ID_BITS-1:0]     WID;
    logic [USER_BITS-1:0]   WUSER;

    // write response channel
    logic                   BVALID;
    logic                   BREADY;
    logic [1:0]             BRESP;
    logic [ID_BITS-1:0]     BID;
    logic [USER_BITS-1:0]   BUSER;

    modport master (
        output AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE,
               AWPROT, AWQOS, AWREGION, AWUSER,
        input  AWREADY,
        output WVALID, WDATA, WSTRB, WLAST, WID, WUSER,
        input  WREADY,
        input  BVALID, BRESP, BID, BUSER,
        output BREADY
    );

    modport slave (
        input  AWVALID, AWADDR, AWID, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE,
               AWPROT, AWQOS, AWREGION, AWUSER,
        output AWREADY,
        input  WVALID, WDATA, WSTRB, WLAST, WID, WUSER,
        output WREADY,
        output BVALID, BRESP, BID, BUSER,
        input  BREADY
    );
endinterface

// File: rtl/axi_wr_to_mem.sv
// Converts one AXI4 write burst at a time into a single TSIM memory write request
// followed by a pass-through data beat per W beat, then returns the B response.
module axi_wr_to_mem #(
    parameter int MEM_LEN_BITS      = 8,
    parameter int MEM_ADDR_BITS     = 32,
    parameter int MEM_DATA_BITS     = 64,
    parameter int MEM_AXI_ID_BITS   = 1,
    parameter int MEM_AXI_USER_BITS = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    axi_wr_to_mem_if.slave           m_axi_data,
    output logic                     mem_req_valid,
    output logic                     mem_req_opcode,
    output logic [MEM_LEN_BITS-1:0]  mem_req_len,
    output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
    output logic                     mem_wr_valid,
    output logic [MEM_DATA_BITS-1:0] mem_wr_bits
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] BEAT_SIZE   = 3'd3;

    state_t                     state;
    logic [MEM_ADDR_BITS-1:0]   addr_q;
    logic [MEM_LEN_BITS-1:0]    len_q;
    logic [MEM_AXI_ID_BITS-1:0] id_q;
    logic [MEM_LEN_BITS-1:0]    beat_cnt;
    logic                       err_q;
    logic                       awready_q;
    logic                       wready_q;
    logic                       bvalid_q;
    logic [1:0]                 bresp_q;
    logic                       req_valid_q;
    logic                       beat_err;
    logic                       last_beat;

    // Sideband fields an INCR-only, full-width bridge has no use for.
    wire unused_sideband = &{1'b0, m_axi_data.AWBURST, m_axi_data.AWLOCK,
                             m_axi_data.AWCACHE, m_axi_data.AWPROT, m_axi_data.AWQOS,
                             m_axi_data.AWREGION, m_axi_data.AWUSER, m_axi_data.WID,
                             m_axi_data.WUSER};

    assign last_beat = (beat_cnt == len_q);
    assign beat_err  = (m_axi_data.WSTRB != '1) || (m_axi_data.WLAST != last_beat);

    always_ff @(posedge clock) begin
        // NOTE: every architectural register is cleared here, including the latched
        // burst fields, because mem_req_len/addr and BID are visible outputs that
        // must read 0 straight after reset.
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            id_q        <= '0;
            beat_cnt    <= '0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            req_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every branch reads the
            // pre-edge value of the state it tests (e.g. err_q when building BRESP).
            unique case (state)
                IDLE: begin
                    awready_q <= 1'b1;
                    if (m_axi_data.AWVALID && awready_q) begin
                        addr_q      <= m_axi_data.AWADDR;
                        len_q       <= m_axi_data.AWLEN;
                        id_q        <= m_axi_data.AWID;
                        beat_cnt    <= '0;
                        err_q       <= (m_axi_data.AWSIZE != BEAT_SIZE);
                        awready_q   <= 1'b0;
                        req_valid_q <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    req_valid_q <= 1'b0;
                    wready_q    <= 1'b1;
                    state       <= DATA;
                end
                DATA: begin
                    if (m_axi_data.WVALID) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_err)
                            err_q <= 1'b1;
                        // The counter, not WLAST, decides where the burst ends.
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;
                            state    <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (m_axi_data.BREADY) begin
                        bvalid_q  <= 1'b0;
                        bresp_q   <= RESP_OKAY;
                        awready_q <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_axi_data.AWREADY = awready_q;
    assign m_axi_data.WREADY  = wready_q;
    assign m_axi_data.BVALID  = bvalid_q;
    assign m_axi_data.BRESP   = bresp_q;
    assign m_axi_data.BID     = id_q;
    assign m_axi_data.BUSER   = '0;

    assign mem_req_valid  = req_valid_q;
    assign mem_req_opcode = req_valid_q;
    assign mem_req_len    = len_q;
    assign mem_req_addr   = addr_q;

    // Beats are forwarded even in a flagged burst; the error only shows up in BRESP.
    assign mem_wr_valid = m_axi_data.WVALID && wready_q;
    assign mem_wr_bits  = mem_wr_valid ? m_axi_data.WDATA : '0;

endmodule

// File: tb/tb_axi_wr_to_mem.sv
// Directed bench for axi_wr_to_mem: scoreboard queues for mem_req, mem_wr and B,
// plus cycle-exact handshake timing checks in the stimulus sequence.
module tb_axi_wr_to_mem;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic        mem_req_opcode;
    logic [7:0]  mem_req_len;
    logic [31:0] mem_req_addr;
    logic        mem_wr_valid;
    logic [63:0] mem_wr_bits;

    int checks = 0;
    int errors = 0;

    logic [40:0] exp_req_q[$];  // {opcode, len, addr}
    logic [63:0] exp_wr_q[$];
    logic [2:0]  exp_b_q[$];    // {id, resp}

    axi_wr_to_mem_if #(.ADDR_BITS(32), .DATA_BITS(64), .ID_BITS(1), .USER_BITS(1)) m_axi_data ();

    axi_wr_to_mem #(
        .MEM_LEN_BITS(8), .MEM_ADDR_BITS(32), .MEM_DATA_BITS(64),
        .MEM_AXI_ID_BITS(1), .MEM_AXI_USER_BITS(1)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .m_axi_data     (m_axi_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard side: compare whatever the DUT emits against the queued expectations.
    always @(negedge clock) begin
        if (mem_req_valid) begin
            check("req_expected", 96'(exp_req_q.size() != 0), 96'd1);
            if (exp_req_q.size() != 0)
                check("mem_req", {mem_req_opcode, mem_req_len, mem_req_addr}, exp_req_q.pop_front());
        end
        if (mem_wr_valid) begin
            check("wr_expected", 96'(exp_wr_q.size() != 0), 96'd1);
            if (exp_wr_q.size() != 0)
                check("mem_wr_bits", mem_wr_bits, exp_wr_q.pop_front());
        end
        if (m_axi_data.BVALID && m_axi_data.BREADY) begin
            check("b_expected", 96'(exp_b_q.size() != 0), 96'd1);
            if (exp_b_q.size() != 0)
                check("b_id_resp", {m_axi_data.BID, m_axi_data.BRESP}, exp_b_q.pop_front());
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_awready"}, m_axi_data.AWREADY, 0);
        check({tag, "_wready"},  m_axi_data.WREADY, 0);
        check({tag, "_bvalid"},  m_axi_data.BVALID, 0);
        check({tag, "_bresp"},   m_axi_data.BRESP, 0);
        check({tag, "_bid"},     m_axi_data.BID, 0);
        check({tag, "_buser"},   m_axi_data.BUSER, 0);
        check({tag, "_mem"}, {mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
                              mem_wr_valid, mem_wr_bits}, 0);
    endtask

    task automatic send_aw(input logic [31:0] addr, input logic [7:0] len,
                           input logic id, input logic [2:0] size);
        int n;
        m_axi_data.AWVALID = 1'b1;
        m_axi_data.AWADDR  = addr;
        m_axi_data.AWLEN   = len;
        m_axi_data.AWID    = id;
        m_axi_data.AWSIZE  = size;
        n = 0;
        while (!m_axi_data.AWREADY && n < 50) begin
            step();
            n++;
        end
        check("awready_wait", m_axi_data.AWREADY, 1);
        exp_req_q.push_back({1'b1, len, addr});
        step();                                   // handshake edge closes cycle t
        m_axi_data.AWVALID = 1'b0;
        check("req_valid_t1", mem_req_valid, 1);
        check("wready_t1", m_axi_data.WREADY, 0);
        check("awready_t1", m_axi_data.AWREADY, 0);
        step();
        check("req_valid_t2", mem_req_valid, 0);
        check("wready_t2", m_axi_data.WREADY, 1);
    endtask

    task automatic w_beat(input logic [63:0] data, input logic last,
                          input logic [7:0] strb, input int gap);
        int n;
        for (int g = 0; g < gap; g++) begin
            m_axi_data.WVALID = 1'b0;
            m_axi_data.WDATA  = {$urandom, $urandom};
            #1;
            check("gap_wr_valid", mem_wr_valid, 0);
            check("gap_wr_bits", mem_wr_bits, 0);
            step();
        end
        m_axi_data.WVALID = 1'b1;
        m_axi_data.WDATA  = data;
        m_axi_data.WLAST  = last;
        m_axi_data.WSTRB  = strb;
        n = 0;
        while (!m_axi_data.WREADY && n < 50) begin
            step();
            n++;
        end
        check("wready_wait", m_axi_data.WREADY, 1);
        exp_wr_q.push_back(data);
        step();
        m_axi_data.WVALID = 1'b0;
        m_axi_data.WLAST  = 1'b0;
        m_axi_data.WSTRB  = 8'hFF;
    endtask

    task automatic b_resp(input logic id, input logic [1:0] resp, input int hold);
        exp_b_q.push_back({id, resp});
        m_axi_data.BREADY = 1'b0;
        for (int h = 0; h < hold; h++) begin
            check("bp_bvalid", m_axi_data.BVALID, 1);
            check("bp_bid_bresp", {m_axi_data.BID, m_axi_data.BRESP}, {id, resp});
            check("bp_awready", m_axi_data.AWREADY, 0);
            step();
        end
        m_axi_data.BREADY = 1'b1;
        step();
        m_axi_data.BREADY = 1'b0;
        check("bvalid_after_b", m_axi_data.BVALID, 0);
        check("awready_after_b", m_axi_data.AWREADY, 1);
    endtask

    task automatic run_burst(input logic [31:0] addr, input logic [7:0] len, input logic id,
                             input logic [2:0] size, input logic [63:0] base, input int gap,
                             input int early_last, input int bad_strb, input logic [1:0] resp,
                             input int hold);
        logic last;
        send_aw(addr, len, id, size);
        for (int i = 0; i <= int'(len); i++) begin
            last = (early_last >= 0) ? (i == early_last) : (i == int'(len));
            w_beat(base + 64'(i), last, (i == bad_strb) ? 8'h0F : 8'hFF, gap);
        end
        check("bvalid_u1", m_axi_data.BVALID, 1);
        check("wready_u1", m_axi_data.WREADY, 0);
        b_resp(id, resp, hold);
    endtask

    initial begin
        reset = 1'b1;
        m_axi_data.AWVALID  = 1'b0;
        m_axi_data.AWADDR   = '0;
        m_axi_data.AWID     = '0;
        m_axi_data.AWLEN    = '0;
        m_axi_data.AWSIZE   = 3'd3;
        m_axi_data.AWBURST  = 2'b01;
        m_axi_data.AWLOCK   = 1'b0;
        m_axi_data.AWCACHE  = '0;
        m_axi_data.AWPROT   = '0;
        m_axi_data.AWQOS    = '0;
        m_axi_data.AWREGION = '0;
        m_axi_data.AWUSER   = '0;
        m_axi_data.WVALID   = 1'b0;
        m_axi_data.WDATA    = '0;
        m_axi_data.WSTRB    = 8'hFF;
        m_axi_data.WLAST    = 1'b0;
        m_axi_data.WID      = '0;
        m_axi_data.WUSER    = '0;
        m_axi_data.BREADY   = 1'b0;

        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();
        check("awready_after_reset", m_axi_data.AWREADY, 1);

        // single beat
        run_burst(32'h1000, 8'd0, 1'b1, 3'd3, 64'hDEADBEEF_00000001, 0, -1, -1, 2'b00, 0);
        // len=3 with WVALID gaps
        run_burst(32'h2000, 8'd3, 1'b0, 3'd3, 64'h10, 2, -1, -1, 2'b00, 0);
        // early WLAST on beat 1
        run_burst(32'h3000, 8'd3, 1'b1, 3'd3, 64'h20, 0, 1, -1, 2'b10, 0);
        // AWSIZE=2
        run_burst(32'h4000, 8'd1, 1'b0, 3'd2, 64'h30, 0, -1, -1, 2'b10, 0);
        // partial strobe
        run_burst(32'h5000, 8'd1, 1'b1, 3'd3, 64'h40, 1, -1, 0, 2'b10, 0);
        // B backpressure for 5 cycles
        run_burst(32'h6000, 8'd1, 1'b1, 3'd3, 64'h50, 0, -1, -1, 2'b00, 5);

        // reset after beat 1 of a len=7 burst
        send_aw(32'h7000, 8'd7, 1'b1, 3'd3);
        w_beat(64'h60, 1'b0, 8'hFF, 0);
        w_beat(64'h61, 1'b0, 8'hFF, 0);
        reset = 1'b1;
        step();
        m_axi_data.WVALID = 1'b1;
        m_axi_data.WDATA  = 64'h62;
        #1;
        check_all_zero("midreset");
        m_axi_data.WVALID = 1'b0;
        reset = 1'b0;
        step();
        check("midreset_bvalid", m_axi_data.BVALID, 0);
        check("midreset_awready", m_axi_data.AWREADY, 1);
        run_burst(32'h8000, 8'd0, 1'b0, 3'd3, 64'h70, 0, -1, -1, 2'b00, 0);

        step();
        check("req_q_drained", 96'(exp_req_q.size()), 0);
        check("wr_q_drained", 96'(exp_wr_q.size()), 0);
        check("b_q_drained", 96'(exp_b_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
